// File: rtl/hex_pixel_shader.sv
// hex_pixel_shader: two-stage pixel classifier for the hexagonal tunnel view.
// Takes the sector/radius of each pixel from the cartesian-to-hex converter and
// produces a 2-bit class for the palette stage. It also owns the six lane walls,
// which move inward once per frame, the world rotation counter and the player
// collision detector.
// Optional build macro HEX_PULSE_EN: adds a beat toggle that flips every 16
// frames and widens the effective centre radius by 4 while it is set.
module hex_pixel_shader #(
    parameter logic [9:0] CENTRE_R = 10'd24,
    parameter logic [9:0] WALL_W   = 10'd12,
    parameter logic [9:0] SPEED    = 10'd2,
    parameter logic [7:0] ROT_DIV  = 8'd30,
    parameter logic [9:0] PLAYER_R = 10'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [2:0] quadrant,
    input  logic [9:0] radius,
    input  logic       wall_we,
    input  logic [2:0] wall_lane,
    input  logic [9:0] wall_radius,
    input  logic [2:0] player_lane,
    output logic [1:0] pix_class,
    output logic       pix_valid_out,
    output logic [2:0] rot,
    output logic       collision
);

    // (a + b) mod 6 for operands in 0..7; results above 5 only arise for
    // out-of-range inputs, which are always masked elsewhere.
    function automatic logic [2:0] lane_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'd6) begin
            s = s - 4'd6;
        end
        return s[2:0];
    endfunction

    // Wall, rotation and pipeline state
    logic [5:0]       wall_act_reg;
    logic [5:0][9:0]  wall_r_reg;
    logic [5:0]       wall_act_next;
    logic [5:0][9:0]  wall_r_next;
    logic [2:0]       rot_reg;
    logic [2:0]       rot_next;
    logic [7:0]       rot_cnt_reg;
    logic [7:0]       rot_cnt_next;
    logic             collision_reg;
    logic             collision_next;

    logic [2:0]       s1_lane_reg;
    logic [9:0]       s1_radius_reg;
    logic             s1_valid_reg;
    logic             s1_bad_reg;
    logic [1:0]       class_reg;
    logic [1:0]       class_next;
    logic             valid2_reg;

    logic [9:0]       centre_eff;   // centre radius for the current frame
    logic [9:0]       centre_next;  // centre radius after this cycle's frame update

`ifdef HEX_PULSE_EN
    logic [3:0] beat_cnt_reg;
    logic       beat_reg;
    logic       beat_next;

    assign beat_next   = (frame_start && (beat_cnt_reg == 4'd15)) ? ~beat_reg : beat_reg;
    assign centre_eff  = beat_reg  ? (CENTRE_R + 10'd4) : CENTRE_R;
    assign centre_next = beat_next ? (CENTRE_R + 10'd4) : CENTRE_R;

    // Beat toggle: flips after every 16th frame_start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= 4'd0;
            beat_reg     <= 1'b0;
        end else begin
            if (frame_start) begin
                beat_cnt_reg <= beat_cnt_reg + 4'd1;
            end
            beat_reg <= beat_next;
        end
    end
`else
    assign centre_eff  = CENTRE_R;
    assign centre_next = CENTRE_R;
`endif

    // Per-lane next wall state. A load on the lane overrides the frame move,
    // so a wall spawned on a frame boundary starts at exactly wall_radius.
    // Deactivation compares against the plain centre radius, never the pulsed one.
    for (genvar gi = 0; gi < 6; gi++) begin : g_lane
        logic [10:0] dec;
        logic        load_hit;
        logic        dies;

        assign dec      = {1'b0, wall_r_reg[gi]} - {1'b0, SPEED};
        assign load_hit = wall_we && (wall_lane == 3'(gi));
        assign dies     = $signed(dec) <= $signed({1'b0, CENTRE_R});

        assign wall_act_next[gi] = load_hit ? 1'b1 :
                                   (frame_start && wall_act_reg[gi] && dies) ? 1'b0 :
                                   wall_act_reg[gi];
        assign wall_r_next[gi]   = load_hit ? wall_radius :
                                   (frame_start && wall_act_reg[gi] && !dies) ? dec[9:0] :
                                   wall_r_reg[gi];
    end

    // Rotation: advance one sector every ROT_DIV frames, wrapping 5 -> 0
    always_comb begin
        rot_next     = rot_reg;
        rot_cnt_next = rot_cnt_reg;
        if (frame_start) begin
            if (rot_cnt_reg == (ROT_DIV - 8'd1)) begin
                rot_cnt_next = 8'd0;
                rot_next     = (rot_reg == 3'd5) ? 3'd0 : rot_reg + 3'd1;
            end else begin
                rot_cnt_next = rot_cnt_reg + 8'd1;
            end
        end
    end

    // Collision is judged on the post-update walls and rotation, so the pulse
    // lands in the cycle right after frame_start.
    logic [2:0] player_world;
    assign player_world = lane_add(player_lane, rot_next);

    always_comb begin
        collision_next = 1'b0;
        if (frame_start && (player_lane <= 3'd5)) begin
            collision_next = wall_act_next[player_world] &&
                             (wall_r_next[player_world] <= (centre_next + PLAYER_R));
        end
    end

    // Stage-2 classification from the stage-1 registers and live wall state
    logic [9:0]  lane_r;
    logic        lane_act;
    logic [10:0] lane_hi;

    assign lane_r   = wall_r_reg[s1_lane_reg];
    assign lane_act = wall_act_reg[s1_lane_reg];
    assign lane_hi  = {1'b0, lane_r} + {1'b0, WALL_W};

    always_comb begin
        class_next = 2'd0;
        if (s1_radius_reg < centre_eff) begin
            class_next = 2'd3;
        end else if (s1_bad_reg) begin
            class_next = 2'd0;
        end else if (lane_act && (s1_radius_reg >= lane_r) && ({1'b0, s1_radius_reg} < lane_hi)) begin
            class_next = 2'd2;
        end else begin
            class_next = {1'b0, s1_lane_reg[0]};
        end
    end

    // Pixel pipeline: stage 1 maps to the world lane, stage 2 holds the class
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_lane_reg   <= 3'd0;
            s1_radius_reg <= 10'd0;
            s1_valid_reg  <= 1'b0;
            s1_bad_reg    <= 1'b0;
            class_reg     <= 2'd0;
            valid2_reg    <= 1'b0;
        end else begin
            s1_lane_reg   <= lane_add(quadrant, rot_reg);
            s1_radius_reg <= radius;
            s1_valid_reg  <= pix_valid;
            s1_bad_reg    <= (quadrant > 3'd5);
            class_reg     <= class_next;
            valid2_reg    <= s1_valid_reg;
        end
    end

    // Game state: walls, rotation and the collision pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wall_act_reg  <= 6'd0;
            wall_r_reg    <= '0;
            rot_reg       <= 3'd0;
            rot_cnt_reg   <= 8'd0;
            collision_reg <= 1'b0;
        end else begin
            wall_act_reg  <= wall_act_next;
            wall_r_reg    <= wall_r_next;
            rot_reg       <= rot_next;
            rot_cnt_reg   <= rot_cnt_next;
            collision_reg <= collision_next;
        end
    end

    assign pix_class     = class_reg;
    assign pix_valid_out = valid2_reg;
    assign rot           = rot_reg;
    assign collision     = collision_reg;

endmodule

// File: tb/tb_hex_pixel_shader.sv
// Testbench for hex_pixel_shader: directed steps followed by randomized rounds,
// all checked against a frame-count based behavioural model.
module tb_hex_pixel_shader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       pix_valid;
    logic [2:0] quadrant;
    logic [9:0] radius;
    logic       wall_we;
    logic [2:0] wall_lane;
    logic [9:0] wall_radius;
    logic [2:0] player_lane;
    logic [1:0] pix_class;
    logic       pix_valid_out;
    logic [2:0] rot;
    logic       collision;

    always #5 clk = ~clk;

    hex_pixel_shader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .pix_valid    (pix_valid),
        .quadrant     (quadrant),
        .radius       (radius),
        .wall_we      (wall_we),
        .wall_lane    (wall_lane),
        .wall_radius  (wall_radius),
        .player_lane  (player_lane),
        .pix_class    (pix_class),
        .pix_valid_out(pix_valid_out),
        .rot          (rot),
        .collision    (collision)
    );

    int checks = 0;
    int passed = 0;
    int failed = 0;

    // Behavioural model: everything derives from the number of frames seen
    int nframes;
    bit act[6];
    int wr[6];

    typedef struct {
        bit v;
        int cls;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int centre_eff(input int nf);
`ifdef HEX_PULSE_EN
        return (((nf / 16) % 2) == 1) ? 28 : 24;
`else
        return 24;
`endif
    endfunction

    function automatic int rot_of(input int nf);
        return (nf / 30) % 6;
    endfunction

    function automatic int ref_class(input int q, input int r);
        int c;
        int wl;
        c = centre_eff(nframes);
        if (r < c) return 3;
        if (q > 5) return 0;
        wl = (q + rot_of(nframes)) % 6;
        if (act[wl] && r >= wr[wl] && r < wr[wl] + 12) return 2;
        return wl % 2;
    endfunction

    task automatic model_reset();
        nframes = 0;
        for (int i = 0; i < 6; i++) begin
            act[i] = 1'b0;
            wr[i]  = 0;
        end
        exp_q.delete();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
    task automatic do_reset(input string tag);
        frame_start = 1'b0;
        wall_we     = 1'b0;
        pix_valid   = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_class"}, 32'(pix_class), 32'd0);
        check({tag, "_valid"}, 32'(pix_valid_out), 32'd0);
        check({tag, "_rot"}, 32'(rot), 32'd0);
        check({tag, "_coll"}, 32'(collision), 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
    endtask

    // One cycle of frame/load activity, mirrored into the model
    task automatic step(input bit fs, input bit we, input int lane, input int rad, output bit exp_coll);
        int pl;
        frame_start = fs;
        wall_we     = we;
        wall_lane   = lane[2:0];
        wall_radius = rad[9:0];
        pix_valid   = 1'b0;
        tick();
        frame_start = 1'b0;
        wall_we     = 1'b0;
        exp_coll    = 1'b0;
        if (fs) begin
            nframes++;
            for (int i = 0; i < 6; i++) begin
                if (act[i]) begin
                    if (wr[i] - 2 <= 24) act[i] = 1'b0;
                    else wr[i] = wr[i] - 2;
                end
            end
        end
        if (we && lane < 6) begin
            act[lane] = 1'b1;
            wr[lane]  = rad;
        end
        if (fs && player_lane < 3'd6) begin
            pl = (int'(player_lane) + rot_of(nframes)) % 6;
            exp_coll = act[pl] && (wr[pl] <= centre_eff(nframes) + 8);
        end
    endtask

    // Count collision pulses in a short window after a frame step
    task automatic coll_window(input bit exp, input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (collision === 1'b1) n++;
            tick();
        end
        check(tag, n, 32'(exp));
    endtask

    // Drive one pixel; the output two cycles later is compared. exp_cls < 0
    // means take the expectation from the model.
    task automatic pix(input bit v, input int q, input int r, input int exp_cls, input string tag);
        exp_t e;
        pix_valid = v;
        quadrant  = q[2:0];
        radius    = r[9:0];
        e.v   = v;
        e.cls = (exp_cls < 0) ? ref_class(q, r) : exp_cls;
        exp_q.push_back(e);
        tick();
        if (exp_q.size() == 2) begin
            e = exp_q.pop_front();
            check({tag, "_vout"}, 32'(pix_valid_out), 32'(e.v));
            if (e.v) check({tag, "_class"}, 32'(pix_class), 32'(e.cls));
        end
    endtask

    task automatic flush(input string tag);
        pix(1'b0, 0, 0, 0, tag);
        pix(1'b0, 0, 0, 0, tag);
        exp_q.delete();
        pix_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c;
        int n;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        quadrant    = 3'd0;
        radius      = 10'd0;
        wall_we     = 1'b0;
        wall_lane   = 3'd0;
        wall_radius = 10'd0;
        player_lane = 3'd7;
        model_reset();

        // Basic classes with no walls
        do_reset("por");
        pix(1'b1, 0, 10, 3, "t1_centre");
        pix(1'b1, 1, 100, 1, "t1_light");
        pix(1'b0, 3, 50, 0, "t1_idle");
        pix(1'b1, 0, 100, 0, "t1_dark");
        pix(1'b1, 7, 100, 0, "t1_badq");
        pix(1'b1, 6, 10, 3, "t1_badq_centre");
        flush("t1_flush");

        // Wall band edges on lane 2
        do_reset("t2rst");
        step(1'b0, 1'b1, 2, 200, c);
        pix(1'b1, 2, 199, 0, "t2_below");
        pix(1'b1, 2, 200, 2, "t2_low_edge");
        pix(1'b1, 2, 211, 2, "t2_high_edge");
        pix(1'b1, 2, 212, 0, "t2_above");
        flush("t2_flush");

        // Wall movement and deactivation on lane 4
        do_reset("t3rst");
        player_lane = 3'd7;
        step(1'b0, 1'b1, 4, 30, c);
        step(1'b1, 1'b0, 0, 0, c);
        pix(1'b1, 4, 28, 2, "t3_f1_at28");
        pix(1'b1, 4, 27, 0, "t3_f1_at27");
        flush("t3_flush");
        step(1'b1, 1'b0, 0, 0, c);
        pix(1'b1, 4, 26, 2, "t3_f2_at26");
        pix(1'b1, 4, 25, 0, "t3_f2_at25");
        flush("t3_flush");
        step(1'b1, 1'b0, 0, 0, c);
        pix(1'b1, 4, 26, 0, "t3_f3_gone26");
        pix(1'b1, 4, 24, 0, "t3_f3_gone24");
        flush("t3_flush");

        // Rotation counter and lane mapping under rotation
        do_reset("t4rst");
        player_lane = 3'd7;
        repeat (29) step(1'b1, 1'b0, 0, 0, c);
        check("t4_rot_29", 32'(rot), 32'd0);
        step(1'b1, 1'b0, 0, 0, c);
        check("t4_rot_30", 32'(rot), 32'd1);
        repeat (150) step(1'b1, 1'b0, 0, 0, c);
        check("t4_rot_180", 32'(rot), 32'd0);
        repeat (30) step(1'b1, 1'b0, 0, 0, c);
        check("t4_rot_210", 32'(rot), 32'd1);
        step(1'b0, 1'b1, 3, 100, c);
        pix(1'b1, 2, 105, 2, "t4_rot_wall");
        pix(1'b1, 2, 95, 1, "t4_rot_stripe");
        pix(1'b1, 3, 105, 0, "t4_rot_lane4");
        flush("t4_flush");

        // Collision
        do_reset("t5rst");
        player_lane = 3'd0;
        step(1'b0, 1'b1, 0, 34, c);
        step(1'b1, 1'b0, 0, 0, c);
        coll_window(1'b1, "t5_hit");
        step(1'b0, 1'b1, 0, 40, c);
        step(1'b1, 1'b0, 0, 0, c);
        coll_window(1'b0, "t5_far");
        player_lane = 3'd6;
        step(1'b0, 1'b1, 0, 34, c);
        step(1'b1, 1'b0, 0, 0, c);
        coll_window(1'b0, "t5_bad_player");

        // Load coinciding with frame_start on the same lane
        do_reset("t6rst");
        player_lane = 3'd7;
        step(1'b0, 1'b1, 1, 80, c);
        step(1'b1, 1'b1, 1, 50, c);
        pix(1'b1, 1, 50, 2, "t6_at50");
        pix(1'b1, 1, 48, 1, "t6_at48");
        pix(1'b1, 1, 61, 2, "t6_at61");
        pix(1'b1, 1, 62, 1, "t6_at62");
        pix(1'b1, 1, 80, 1, "t6_old80");
        flush("t6_flush");

        // Randomized rounds against the model
        do_reset("rnd_rst");
        for (int round = 0; round < 6; round++) begin
            for (int op = 0; op < 20; op++) begin
                int sel;
                int rad;
                sel = $urandom_range(0, 3);
                rad = ($urandom_range(0, 4) == 0) ? $urandom_range(1000, 1023) : $urandom_range(20, 80);
                if (sel == 0) begin
                    step(1'b0, 1'b1, $urandom_range(0, 7), rad, c);
                end else if (sel == 3) begin
                    player_lane = 3'd7;
                    n = $urandom_range(1, 40);
                    repeat (n) step(1'b1, 1'b0, 0, 0, c);
                end else begin
                    player_lane = 3'($urandom_range(0, 7));
                    step(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 7), rad, c);
                    coll_window(c, "rnd_coll");
                end
            end
            check("rnd_rot", 32'(rot), 32'(rot_of(nframes)));
            for (int p = 0; p < 40; p++) begin
                int r;
                r = ($urandom_range(0, 5) == 0) ? $urandom_range(1000, 1023) : $urandom_range(0, 120);
                pix(1'($urandom_range(0, 4) != 0), $urandom_range(0, 7), r, -1, "rnd_pix");
            end
            flush("rnd_flush");
        end

        // Reset while pixels are in flight and walls are live
        player_lane = 3'd7;
        step(1'b0, 1'b1, 5, 60, c);
        pix(1'b1, 5, 60, -1, "t8_pre");
        pix(1'b1, 5, 61, -1, "t8_pre");
        pix_valid = 1'b1;
        do_reset("t8_mid");
        check("t8_refill_valid", 32'(pix_valid_out), 32'd0);
        tick();
        check("t8_refill_valid2", 32'(pix_valid_out), 32'd0);
        check("t8_rot_clear", 32'(rot), 32'd0);
        pix(1'b1, 5, 60, 1, "t8_wall_gone");
        pix(1'b1, 5, 65, 1, "t8_wall_gone2");
        flush("t8_flush");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
